// File: rtl/response_resolver_if.sv
// ============================================================================
// Module   : response_resolver_if
// Brief    : Tag input / indexed-readout handshake bundle for response_resolver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface response_resolver_if #(
    parameter int N     = 100,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N + 1)
);
    logic [N-1:0]     tags;
    logic             start;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             some;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    // Master: the tag register / readout controller side.
    modport master (
        output tags, start, abort, out_ready,
        input  out_valid, out_index, out_last, some, count, busy, done
    );

    // Slave: the resolver itself.
    modport slave (
        input  tags, start, abort, out_ready,
        output out_valid, out_index, out_last, some, count, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/response_resolver.sv
// ============================================================================
// Module   : response_resolver
// Brief    : Multiple-response resolver; emits tagged word indices lowest-first
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module response_resolver #(
    parameter int N     = 100,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    response_resolver_if.slave  bus
);

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_pending;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_index;
    logic             r_out_last;
    logic             r_some;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [N-1:0]     w_enc_in;
    logic [IDX_W-1:0] w_low_idx;
    logic             w_enc_any;
    logic             w_enc_last;
    logic [CNT_W-1:0] w_popcnt;
    logic             w_accept;

    // One shared encoder: in IDLE it looks at the incoming tags, in SCAN at
    // the pending set with its lowest bit (the index on display) removed.
    // out_index is always the lowest set bit, so x & (x-1) drops exactly it.
    always_comb begin
        w_enc_in = (r_state == S_IDLE) ? bus.tags : (r_pending & (r_pending - c_one));
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_enc_in[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_enc_any  = |w_enc_in;
        w_enc_last = w_enc_any && ((w_enc_in & (w_enc_in - c_one)) == '0);
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < N; i++) begin
            w_popcnt = w_popcnt + CNT_W'(bus.tags[i]);
        end
    end

    always_comb begin
        w_accept = r_out_valid & bus.out_ready;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_some      <= 1'b0;
            r_count     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_pending   <= bus.tags;
                        r_count     <= w_popcnt;
                        r_some      <= w_enc_any;
                        r_out_valid <= w_enc_any;
                        r_out_index <= w_low_idx;
                        r_out_last  <= w_enc_last;
                        r_state     <= w_enc_any ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    // abort overrides a handshake landing in the same cycle
                    if (bus.abort) begin
                        r_pending   <= '0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_accept) begin
                        r_pending   <= w_enc_in;
                        r_out_valid <= w_enc_any;
                        r_out_index <= w_low_idx;
                        r_out_last  <= w_enc_last;
                        if (!w_enc_any) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_pending   <= '0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_done      <= !bus.abort;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;
    assign bus.some      = r_some;
    assign bus.count     = r_count;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_response_resolver.sv
// ============================================================================
// Module   : tb_response_resolver
// Brief    : Scoreboard bench for response_resolver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_response_resolver;

    localparam int N     = 100;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic CLK = 1'b0;
    logic RST = 1'b1;

    response_resolver_if #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    response_resolver #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    int unsigned exp_q[$];
    int          exp_cnt = 0;
    int unsigned e_idx;

    logic             hold_v = 1'b0;
    logic [IDX_W-1:0] hold_idx;
    logic             hold_last;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pushes the expected index stream, then issues a one-cycle start.
    task automatic do_start(input logic [N-1:0] t);
        bus.tags  = t;
        bus.start = 1'b1;
        exp_cnt   = 0;
        for (int i = 0; i < N; i++) begin
            if (t[i]) begin
                exp_q.push_back(i);
                exp_cnt++;
            end
        end
        tick();
        bus.start = 1'b0;
    endtask

    // Drives out_ready from rdy (bit k = cycle k+1, all-ones afterwards).
    task automatic wait_done(input string tag, input logic [15:0] rdy,
                             input int lat, input int bsy);
        int cyc  = 0;
        int nb   = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 300) begin
            bus.out_ready = (cyc < 16) ? rdy[cyc] : 1'b1;
            cyc++;
            @(negedge CLK);
            if (bus.busy) nb++;
            if (bus.done) seen = 1'b1;
            else tick();
        end
        chk({tag, "_done_seen"},   seen, 1);
        chk({tag, "_latency"},     cyc, lat);
        chk({tag, "_busy_cycles"}, nb, bsy);
        chk({tag, "_count"},       bus.count, exp_cnt);
        chk({tag, "_some"},        bus.some, (exp_cnt != 0));
        chk({tag, "_queue_left"},  exp_q.size(), 0);
        tick();
    endtask

    // Scoreboard monitor: pops on every accepted handshake, checks hold stability.
    always @(negedge CLK) begin
        if (RST) begin
            hold_v = 1'b0;
        end else begin
            if (bus.done) n_done++;
            if (hold_v && bus.out_valid) begin
                chk("hold_index", bus.out_index, hold_idx);
                chk("hold_last",  bus.out_last,  hold_last);
            end
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e_idx = exp_q.pop_front();
                    chk("index", bus.out_index, e_idx);
                    chk("last",  bus.out_last, (exp_q.size() == 0));
                end
            end
            hold_v    = bus.out_valid && !bus.out_ready && !bus.abort;
            hold_idx  = bus.out_index;
            hold_last = bus.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] t;

        bus.tags      = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        RST           = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_some",      bus.some,      0);
        chk("rst_count",     bus.count,     0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_done",      bus.done,      0);
        RST = 1'b0;
        tick();

        // all-zero snapshot goes straight to DONE
        do_start('0);
        wait_done("zero", 16'hFFFF, 2, 1);

        // sparse responders, full throughput
        t = '0; t[3] = 1'b1; t[17] = 1'b1; t[99] = 1'b1;
        do_start(t);
        wait_done("sparse", 16'hFFFF, 5, 4);

        // same snapshot with back-pressure 1,0,0,1,1
        do_start(t);
        wait_done("backpressure", 16'hFFF9, 7, 6);

        // all ones
        do_start('1);
        wait_done("all_ones", 16'hFFFF, N + 2, N + 1);

        // abort after the first of two responders
        t = '0; t[5] = 1'b1; t[6] = 1'b1;
        do_start(t);
        bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("abort_busy",  bus.busy,      0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_done",  bus.done,      0);
        chk("abort_count", bus.count,     2);
        chk("abort_some",  bus.some,      1);

        // abort together with start in IDLE: start is dropped
        t = '0; t[40] = 1'b1;
        bus.tags  = t;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge CLK);
        chk("abort_start_busy", bus.busy, 0);
        tick();
        do_start(t);
        wait_done("after_abort", 16'hFFFF, 3, 2);

        // start/tags activity while busy is ignored, then RST mid-SCAN
        do_start('1);
        bus.out_ready = 1'b1;
        t = '0; t[50] = 1'b1;
        bus.tags  = t;
        bus.start = 1'b1;
        repeat (5) tick();
        RST       = 1'b1;
        bus.start = 1'b0;
        tick();
        @(negedge CLK);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_index", bus.out_index, 0);
        chk("midrst_out_last",  bus.out_last,  0);
        chk("midrst_some",      bus.some,      0);
        chk("midrst_count",     bus.count,     0);
        chk("midrst_busy",      bus.busy,      0);
        chk("midrst_done",      bus.done,      0);
        exp_q.delete();
        RST = 1'b0;
        tick();

        chk("done_pulses", n_done, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
